maint_scheduler: RTL and testbench

MAINT_SCHEDULER -- requirements
Module: maint_scheduler

---
 rtl/maint_scheduler_pkg.sv | 34 +++
 rtl/maint_prio_pick.sv | 27 ++
 rtl/maint_scheduler.sv | 143 ++++++++++++++
 tb/tb_maint_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maint_scheduler_pkg.sv
// Shared encodings for the maintenance scheduler: handler selection codes,
// FSM states, and the mapping from a selection code to its ack/pending bit.
package maint_scheduler_pkg;

  typedef enum logic [1:0] {
    MSEL_NONE = 2'd0,
    MSEL_AREF = 2'd1,
    MSEL_ZQ   = 2'd2,
    MSEL_PRD  = 2'd3
  } msel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    OFFER = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Request vectors are ordered {prd, zq, aref}.
  localparam int NUM_REQ = 3;

  function automatic logic [NUM_REQ-1:0] msel_onehot(input msel_e sel);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (sel)
      MSEL_AREF: oh = 3'b001;
      MSEL_ZQ:   oh = 3'b010;
      MSEL_PRD:  oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/maint_prio_pick.sv
// Combinational winner selection: starved pending requests first, then the
// fixed order aref > zq > prd within whichever group is chosen.
module maint_prio_pick
  import maint_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [NUM_REQ-1:0] starved_i,
  output msel_e              win_o
);

  logic [NUM_REQ-1:0] starved_pend;
  logic [NUM_REQ-1:0] cand;

  always_comb begin
    starved_pend = pend_i & starved_i;
    cand         = (|starved_pend) ? starved_pend : pend_i;
    win_o        = MSEL_NONE;
    if (cand[0]) begin
      win_o = MSEL_AREF;
    end else if (cand[1]) begin
      win_o = MSEL_ZQ;
    end else if (cand[2]) begin
      win_o = MSEL_PRD;
    end
  end

endmodule

// File: rtl/maint_scheduler.sv
// Arbitrates refresh / ZQ / periodic-read maintenance against application
// traffic: blocks the app, waits for the dispatcher to drain, offers one winner.
module maint_scheduler
  import maint_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       aref_req,
  input  logic       zq_req,
  input  logic       prd_req,
  output logic       aref_ack,
  output logic       zq_ack,
  output logic       prd_ack,
  input  logic       dispatcher_busy,
  output logic       app_block,
  output logic       maint_valid,
  output logic [1:0] maint_sel,
  input  logic       maint_ready,
  input  logic       seq_done,
  output logic       timeout_err
);

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [11:0] RUN_MAX    = 12'(DONE_TIMEOUT);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [3:0]         starve_q [NUM_REQ];
  logic [3:0]         starve_d [NUM_REQ];
  logic [11:0]        run_cnt_q, run_cnt_d;
  msel_e              sel_q, sel_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] ack_vec;
  logic [NUM_REQ-1:0] win_oh;
  logic [11:0]        run_cnt_inc;
  msel_e              win;
  logic               accept;

  assign req_vec     = {prd_req, zq_req, aref_req};
  assign run_cnt_inc = run_cnt_q + 12'd1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = (starve_q[i] == STARVE_MAX);
    end
  end

  maint_prio_pick u_pick (
    .pend_i    (pend_q),
    .starved_i (starved),
    .win_o     (win)
  );

  assign win_oh = msel_onehot(win);

  // Acks are decoded from registered state, so they fire in the accept cycle.
  assign accept  = (state_q == OFFER) && maint_ready;
  assign ack_vec = accept ? msel_onehot(sel_q) : '0;

  assign aref_ack    = ack_vec[0];
  assign zq_ack      = ack_vec[1];
  assign prd_ack     = ack_vec[2];
  assign maint_valid = (state_q == OFFER);
  assign maint_sel   = sel_q;
  assign app_block   = !((state_q == IDLE) && (pend_q == '0));
  assign timeout_err = timeout_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = (pend_q & ~ack_vec) | req_vec;
    starve_d  = starve_q;
    run_cnt_d = run_cnt_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (|pend_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!dispatcher_busy) begin
          if (win != MSEL_NONE) begin
            sel_d   = win;
            state_d = OFFER;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (win_oh[i]) begin
                starve_d[i] = 4'd0;
              end else if (pend_q[i] && (starve_q[i] != STARVE_MAX)) begin
                starve_d[i] = starve_q[i] + 4'd1;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      OFFER: begin
        if (maint_ready) begin
          state_d   = RUN;
          sel_d     = MSEL_NONE;
          run_cnt_d = 12'd0;
        end
      end
      RUN: begin
        // seq_done wins over a timeout landing in the same cycle.
        if (seq_done) begin
          state_d = (|pend_q) ? DRAIN : IDLE;
        end else if (run_cnt_inc == RUN_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          run_cnt_d = run_cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      starve_q  <= '{default: 4'd0};
      run_cnt_q <= 12'd0;
      sel_q     <= MSEL_NONE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      starve_q  <= starve_d;
      run_cnt_q <= run_cnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_maint_scheduler.sv
// Bench for maint_scheduler: directed scenarios plus a randomized phase, with
// grants checked by a monitor against an expected-grant queue.
module tb_maint_scheduler;

  localparam int SL = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       aref_req = 1'b0, zq_req = 1'b0, prd_req = 1'b0;
  logic       aref_ack, zq_ack, prd_ack;
  logic       dispatcher_busy = 1'b0;
  logic       app_block, maint_valid;
  logic [1:0] maint_sel;
  logic       maint_ready = 1'b0;
  logic       seq_done = 1'b0;
  logic       timeout_err;

  maint_scheduler #(.STARVE_LIMIT(SL), .DONE_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .aref_req        (aref_req),
    .zq_req          (zq_req),
    .prd_req         (prd_req),
    .aref_ack        (aref_ack),
    .zq_ack          (zq_ack),
    .prd_ack         (prd_ack),
    .dispatcher_busy (dispatcher_busy),
    .app_block       (app_block),
    .maint_valid     (maint_valid),
    .maint_sel       (maint_sel),
    .maint_ready     (maint_ready),
    .seq_done        (seq_done),
    .timeout_err     (timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  bit   watch_block = 1'b0;

  // Reference model: pending set and per-request loss counts, indices 0=aref 1=zq 2=prd.
  bit [2:0] m_pend;
  int       m_starve[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {prd_req, zq_req, aref_req} = 3'b000;
    dispatcher_busy = 1'b0;
    maint_ready = 1'b0;
    seq_done = 1'b0;
    watch_block = 1'b0;
    m_pend = 3'b000;
    for (int i = 0; i < 3; i++) m_starve[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_req(input logic [2:0] m);
    {prd_req, zq_req, aref_req} = m;
    tick();
    {prd_req, zq_req, aref_req} = 3'b000;
  endtask

  task automatic finish_run(input int run_len);
    repeat (run_len) tick();
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
  endtask

  // Waits for an offer, optionally holds ready low for rwait cycles (checking
  // the selection stays put), then accepts. Returns at the first RUN cycle.
  task automatic serve_offer(input int rwait);
    int n;
    logic [1:0] sel0;
    maint_ready = (rwait == 0);
    n = 0;
    @(negedge clk);
    while (!maint_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_seen", int'(maint_valid), 1);
    sel0 = maint_sel;
    for (int i = 0; i < rwait; i++) begin
      tick();
      maint_ready = (i == rwait - 1);
      seq_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("offer_hold_valid", int'(maint_valid), 1);
      check("offer_hold_sel", int'(maint_sel), int'(sel0));
    end
    tick();
    maint_ready = 1'b0;
    seq_done = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int m_pick();
    for (int i = 0; i < 3; i++) if (m_pend[i] && m_starve[i] == SL) return i;
    for (int i = 0; i < 3; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic m_select();
    int w;
    w = m_pick();
    for (int i = 0; i < 3; i++) begin
      if (i == w) m_starve[i] = 0;
      else if (m_pend[i] && m_starve[i] < SL) m_starve[i]++;
    end
    if (w >= 0) begin
      m_pend[w] = 1'b0;
      exp_q.push_back(2'(w + 1));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] mon_acks;
  int         mon_obs, mon_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_acks = {prd_ack, zq_ack, aref_ack};
      if (mon_acks != 3'b000) begin
        mon_obs = (mon_acks == 3'b001) ? 1 : (mon_acks == 3'b010) ? 2 :
                  (mon_acks == 3'b100) ? 3 : 0;
        mon_exp = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
        total++;
        if (mon_obs != mon_exp || !(maint_valid && maint_ready) || mon_obs != int'(maint_sel)) begin
          bad++;
          $display("FAIL grant: got ack=%b sel=%0d valid=%0b ready=%0b expected sel=%0d (t=%0t)",
                   mon_acks, maint_sel, maint_valid, maint_ready, mon_exp, $time);
        end
      end else if (maint_valid && maint_ready) begin
        total++;
        bad++;
        $display("FAIL missing_ack: got no ack with sel=%0d accepted (t=%0t)", maint_sel, $time);
      end
      if (watch_block) begin
        total++;
        if (!app_block) begin
          bad++;
          $display("FAIL app_block_hold: got 0 expected 1 (t=%0t)", $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit in_run;
    logic [2:0] mask;

    // Reset state
    @(negedge clk);
    check("rst_valid", int'(maint_valid), 0);
    check("rst_sel", int'(maint_sel), 0);
    check("rst_acks", int'({aref_ack, zq_ack, prd_ack}), 0);
    check("rst_block", int'(app_block), 0);
    check("rst_timeout", int'(timeout_err), 0);

    // Scenario 1: single aref, exact latency
    do_reset();
    maint_ready = 1'b1;
    aref_req = 1'b1;
    exp_q.push_back(2'd1);
    @(negedge clk);
    check("s1_c0_block", int'(app_block), 0);
    tick();
    aref_req = 1'b0;
    @(negedge clk);
    check("s1_c1_block", int'(app_block), 1);
    check("s1_c1_valid", int'(maint_valid), 0);
    tick();
    @(negedge clk);
    check("s1_c2_valid", int'(maint_valid), 0);
    tick();
    @(negedge clk);
    check("s1_c3_valid", int'(maint_valid), 1);
    check("s1_c3_sel", int'(maint_sel), 1);
    check("s1_c3_ack", int'(aref_ack), 1);
    tick();
    @(negedge clk);
    check("s1_c4_ack", int'(aref_ack), 0);
    check("s1_c4_valid", int'(maint_valid), 0);
    repeat (6) tick();
    seq_done = 1'b1;
    @(negedge clk);
    check("s1_c10_block", int'(app_block), 1);
    tick();
    seq_done = 1'b0;
    @(negedge clk);
    check("s1_c11_block", int'(app_block), 0);
    maint_ready = 1'b0;

    // Scenario 2: all three together, served in priority order
    do_reset();
    pulse_req(3'b111);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    watch_block = 1'b1;
    serve_offer(0);
    finish_run(3);
    serve_offer(2);
    finish_run(4);
    serve_offer(1);
    watch_block = 1'b0;
    finish_run(2);
    tick();
    @(negedge clk);
    check("s2_block_end", int'(app_block), 0);
    check("s2_sb_empty", exp_q.size(), 0);

    // Scenario 3: prd starves behind repeated aref
    do_reset();
    pulse_req(3'b101);
    repeat (8) exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    for (int g = 0; g < 10; g++) begin
      serve_offer(g % 3);
      if (g < 8) pulse_req(3'b001);
      finish_run(2);
    end
    tick();
    @(negedge clk);
    check("s3_sb_empty", exp_q.size(), 0);
    check("s3_block_end", int'(app_block), 0);

    // Scenario 4: dispatcher busy holds DRAIN
    do_reset();
    dispatcher_busy = 1'b1;
    pulse_req(3'b010);
    exp_q.push_back(2'd2);
    for (int i = 0; i < 50; i++) begin
      seq_done = (i == 20);
      @(negedge clk);
      check("s4_busy_valid", int'(maint_valid), 0);
      check("s4_busy_block", int'(app_block), 1);
      tick();
    end
    seq_done = 1'b0;
    dispatcher_busy = 1'b0;
    @(negedge clk);
    check("s4_fall_valid", int'(maint_valid), 0);
    tick();
    @(negedge clk);
    check("s4_offer_valid", int'(maint_valid), 1);
    check("s4_offer_sel", int'(maint_sel), 2);
    tick();
    maint_ready = 1'b1;
    @(negedge clk);
    tick();
    maint_ready = 1'b0;
    finish_run(2);
    check("s4_sb_empty", exp_q.size(), 0);

    // Scenario 5: missing seq_done -> sticky timeout, then normal service
    do_reset();
    pulse_req(3'b001);
    exp_q.push_back(2'd1);
    serve_offer(0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      check("s5_no_timeout", int'(timeout_err), 0);
      tick();
    end
    @(negedge clk);
    check("s5_timeout", int'(timeout_err), 1);
    check("s5_idle_block", int'(app_block), 0);
    check("s5_idle_valid", int'(maint_valid), 0);
    repeat (5) tick();
    @(negedge clk);
    check("s5_sticky", int'(timeout_err), 1);
    pulse_req(3'b010);
    exp_q.push_back(2'd2);
    serve_offer(1);
    finish_run(2);
    tick();
    @(negedge clk);
    check("s5_sticky_after", int'(timeout_err), 1);
    check("s5_sb_empty", exp_q.size(), 0);

    // Scenario 6: reset during OFFER, held zq re-granted; set beats clear
    do_reset();
    zq_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!maint_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s6_offer", int'(maint_valid), 1);
    tick();
    rst_n = 1'b0;
    maint_ready = 1'b1;
    @(negedge clk);
    check("s6_rst_valid", int'(maint_valid), 0);
    check("s6_rst_sel", int'(maint_sel), 0);
    check("s6_rst_acks", int'({aref_ack, zq_ack, prd_ack}), 0);
    check("s6_rst_block", int'(app_block), 0);
    tick();
    rst_n = 1'b1;
    maint_ready = 1'b0;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    serve_offer(1);
    zq_req = 1'b0;
    finish_run(2);
    serve_offer(0);
    finish_run(2);
    tick();
    @(negedge clk);
    check("s6_block_end", int'(app_block), 0);
    check("s6_sb_empty", exp_q.size(), 0);

    // Randomized phase against the reference model
    do_reset();
    in_run = 1'b0;
    repeat (40) begin
      mask = 3'($urandom_range(0, 7));
      if (m_pend == 3'b000 && mask == 3'b000) mask = 3'b001 << $urandom_range(0, 2);
      if (mask != 3'b000) pulse_req(mask);
      m_pend |= mask;
      if (in_run) begin
        repeat ($urandom_range(0, 3)) tick();
        seq_done = 1'b1;
        tick();
        seq_done = 1'b0;
      end
      m_select();
      serve_offer($urandom_range(0, 3));
      in_run = 1'b1;
    end
    while (m_pend != 3'b000) begin
      finish_run($urandom_range(0, 3));
      m_select();
      serve_offer($urandom_range(0, 2));
    end
    finish_run(1);
    tick();
    @(negedge clk);
    check("rnd_block_end", int'(app_block), 0);
    check("rnd_timeout", int'(timeout_err), 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
